// File: rtl/dcache_axi_bridge.sv
// Line refill/writeback engine between the data cache and an AXI3 master port.
// One 128-bit line transaction is in flight at a time; all AXI outputs are registered.
module dcache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'h1,
    parameter int         BEATS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_write_en,
    input  logic [BEATS*32-1:0]   req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BEATS*32-1:0]   resp_data,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [31:0]           araddr,
    output logic [3:0]            arid,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [3:0]            rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           awaddr,
    output logic [3:0]            awid,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [3:0]            wid,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp
);
    localparam int LINE_W = BEATS * 32;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [31:0]         addr_q, addr_d;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q, resp_valid_q;
    logic [31:0]         wdata_q;

    // Completion is by beat count and the B handshake alone, so these fields carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, req_addr[3:0]};

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = line_q;

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arid    = AXI_ID;
    assign arlen   = 4'(BEATS - 1);
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign rready  = rready_q;

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awid    = AXI_ID;
    assign awlen   = 4'(BEATS - 1);
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wvalid  = wvalid_q;
    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = 4'hF;
    assign wlast   = wlast_q;
    assign bready  = bready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[31:4], 4'b0000};
                    line_d  = req_data;
                    state_d = req_write_en ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && arready) begin
                    cnt_d   = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid && rready_q) begin
                    line_d[32*cnt_q +: 32] = rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = RESP;
                end
            end
            WR_ADDR: begin
                if (awvalid_q && awready) begin
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (wvalid_q && wready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                // Write completion returns an all-zero line.
                if (bvalid && bready_q) begin
                    line_d  = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel strobes are registered from the next state so they line up with the state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            arvalid_q    <= (state_d == RD_ADDR);
            rready_q     <= (state_d == RD_DATA);
            awvalid_q    <= (state_d == WR_ADDR);
            wvalid_q     <= (state_d == WR_DATA);
            wdata_q      <= line_d[32*cnt_d +: 32];
            wlast_q      <= (state_d == WR_DATA) && (cnt_d == LAST_BEAT);
            bready_q     <= (state_d == WR_RESP);
            resp_valid_q <= (state_d == RESP);
        end
    end
endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed table-driven bench for dcache_axi_bridge with a cycle-level AXI slave model.
module tb_dcache_axi_bridge;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_write_en;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic         resp_valid, resp_ready;
    logic [127:0] resp_data;
    logic         arvalid, arready;
    logic [31:0]  araddr;
    logic [3:0]   arid, arlen, arcache;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst, arlock;
    logic         rvalid, rready, rlast;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         awvalid, awready;
    logic [31:0]  awaddr;
    logic [3:0]   awid, awlen, awcache;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, awlock;
    logic         wvalid, wready, wlast;
    logic [3:0]   wid, wstrb;
    logic [31:0]  wdata;
    logic         bvalid, bready;
    logic [3:0]   bid;
    logic [1:0]   bresp;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dcache_axi_bridge #(.AXI_ID(4'h1), .BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write_en(req_write_en), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] data;
        logic [127:0] rd;
        int           ax_wait;
        logic         r_gap;
        logic         w_tog;
        int           resp_wait;
        int           rlast_mode;   // 0: on beat 4, 1: on beat 2, 2: never
        int           abort_after;  // >0: reset after this many R beats
        logic         chain;        // request presented during the previous response handshake
        logic [127:0] exp_resp;
        int           exp_first;
        logic [31:0]  exp_ax;
    } vec_t;

    localparam int NV = 10;
    vec_t tv[NV];

    function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [127:0] data,
                                input logic [127:0] rd, input int ax_wait, input logic r_gap,
                                input logic w_tog, input int resp_wait, input int rlast_mode,
                                input int abort_after, input logic chain, input logic [127:0] exp_resp,
                                input int exp_first, input logic [31:0] exp_ax);
        vec_t v;
        v.addr = addr; v.we = we; v.data = data; v.rd = rd; v.ax_wait = ax_wait;
        v.r_gap = r_gap; v.w_tog = w_tog; v.resp_wait = resp_wait; v.rlast_mode = rlast_mode;
        v.abort_after = abort_after; v.chain = chain; v.exp_resp = exp_resp;
        v.exp_first = exp_first; v.exp_ax = exp_ax;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_txn(input int i);
        vec_t v;
        logic [127:0] rdw, wcap, got_resp, prev_resp;
        logic [31:0]  ax_addr, prev_ar, prev_aw, prev_wdata;
        logic [21:0]  ax_attr;
        logic         done, ar_done, aw_done, b_done, r_bubble, prev_wlast;
        logic         ar_stall, aw_stall, w_stall, resp_stall;
        int           ar_wait, resp_wait, rbeat, wbeat, first_resp, stab_err, rr_err, proto_err;
        v = tv[i];
        rdw = v.rd; wcap = '0; got_resp = '0; prev_resp = '0; ax_addr = '0; ax_attr = '0;
        prev_ar = '0; prev_aw = '0; prev_wdata = '0; prev_wlast = 1'b0;
        done = 1'b0; ar_done = 1'b0; aw_done = 1'b0; b_done = 1'b0; r_bubble = 1'b0;
        ar_stall = 1'b0; aw_stall = 1'b0; w_stall = 1'b0; resp_stall = 1'b0;
        ar_wait = v.ax_wait; resp_wait = v.resp_wait; rbeat = 0; wbeat = 0; first_resp = -1;
        stab_err = 0; rr_err = 0; proto_err = 0;

        @(negedge clk);
        req_valid = 1'b1; req_addr = v.addr; req_write_en = v.we; req_data = v.data;
        check($sformatf("row%0d req_ready at accept", i), 128'(req_ready), 128'(1));

        for (int c = 1; c <= 300 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready) rr_err++;
            if (ar_stall && (!arvalid || araddr != prev_ar)) stab_err++;
            if (aw_stall && (!awvalid || awaddr != prev_aw)) stab_err++;
            if (w_stall && (!wvalid || wdata != prev_wdata || wlast != prev_wlast)) stab_err++;
            if (resp_stall && (!resp_valid || resp_data != prev_resp)) stab_err++;
            if (v.we ? (arvalid || rready) : (awvalid || wvalid || bready)) proto_err++;
            if (wvalid && !aw_done) proto_err++;
            if (resp_valid && v.we && !b_done) proto_err++;
            if (resp_valid && !v.we && rbeat != 4) proto_err++;
            if (wvalid && (wstrb != 4'hF || wid != 4'h1 || wlast != (wbeat == 3))) proto_err++;

            arready = arvalid && (ar_wait == 0);
            awready = awvalid && (ar_wait == 0);
            if ((arvalid || awvalid) && ar_wait > 0) ar_wait--;
            rvalid = ar_done && (rbeat < 4) && !r_bubble;
            rdata  = rdw[32*(rbeat%4) +: 32];
            rlast  = rvalid && ((v.rlast_mode == 0) ? (rbeat == 3) : (v.rlast_mode == 1) ? (rbeat == 1) : 1'b0);
            rid    = 4'h1;
            rresp  = 2'b00;
            wready = v.w_tog ? (c % 2 == 0) : 1'b1;
            bvalid = (wbeat == 4) && !b_done;
            bid    = 4'h1;
            bresp  = 2'b00;
            resp_ready = resp_valid && (resp_wait == 0);
            if (resp_valid && resp_wait > 0) resp_wait--;

            if (resp_valid && first_resp < 0) first_resp = c;
            if (arvalid && arready) begin
                ar_done = 1'b1; ax_addr = araddr;
                ax_attr = {arid, arlen, arsize, arburst, arlock, arcache, arprot};
            end
            if (awvalid && awready) begin
                aw_done = 1'b1; ax_addr = awaddr;
                ax_attr = {awid, awlen, awsize, awburst, awlock, awcache, awprot};
            end
            ar_stall = arvalid && !arready; prev_ar = araddr;
            aw_stall = awvalid && !awready; prev_aw = awaddr;
            if (rvalid && rready) begin
                rbeat++; r_bubble = v.r_gap;
            end else r_bubble = 1'b0;
            if (wvalid && wready) begin
                if (wbeat < 4) wcap[32*wbeat +: 32] = wdata;
                else proto_err++;
                wbeat++;
            end
            w_stall = wvalid && !wready; prev_wdata = wdata; prev_wlast = wlast;
            if (bvalid && bready) b_done = 1'b1;
            resp_stall = resp_valid && !resp_ready; prev_resp = resp_data;
            if (resp_valid && resp_ready) begin
                done = 1'b1; got_resp = resp_data;
                if (i + 1 < NV && tv[i+1].chain) begin
                    req_valid = 1'b1; req_addr = tv[i+1].addr;
                    req_write_en = tv[i+1].we; req_data = tv[i+1].data;
                end
            end
            if (v.abort_after > 0 && rbeat == v.abort_after) done = 1'b1;
        end

        check($sformatf("row%0d completed within budget", i), 128'(done), 128'(1));
        if (v.abort_after == 0) begin
            check($sformatf("row%0d axaddr", i), 128'(ax_addr), 128'(v.exp_ax));
            check($sformatf("row%0d ax id/len/size/burst/lock/cache/prot", i), 128'(ax_attr),
                  128'({4'h1, 4'd3, 3'd2, 2'b01, 2'b00, 4'h0, 3'h0}));
            check($sformatf("row%0d first resp_valid cycle", i), 128'(first_resp), 128'(v.exp_first));
            check($sformatf("row%0d resp_data", i), got_resp, v.exp_resp);
            check($sformatf("row%0d beat count", i), 128'(v.we ? wbeat : rbeat), 128'(4));
            if (v.we) check($sformatf("row%0d wdata beats", i), wcap, v.data);
            check($sformatf("row%0d stability errors", i), 128'(stab_err), 128'(0));
            check($sformatf("row%0d req_ready while busy", i), 128'(rr_err), 128'(0));
            check($sformatf("row%0d protocol errors", i), 128'(proto_err), 128'(0));
        end
    endtask

    initial begin
        tv[0] = mk(32'h1000_0014, 1'b0, '0, 128'h44444444_33333333_22222222_11111111,
                   0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 128'h44444444_33333333_22222222_11111111, 6, 32'h1000_0010);
        tv[1] = mk(32'h0000_2000, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, '0,
                   0, 1'b0, 1'b0, 0, 0, 0, 1'b0, '0, 7, 32'h0000_2000);
        tv[2] = mk(32'h0000_ABCC, 1'b0, '0, 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0,
                   3, 1'b1, 1'b0, 5, 0, 0, 1'b0, 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0, 12, 32'h0000_ABC0);
        tv[3] = mk(32'h8000_004C, 1'b1, 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA, '0,
                   0, 1'b0, 1'b1, 5, 0, 0, 1'b0, '0, 10, 32'h8000_0040);
        tv[4] = mk(32'h0000_0108, 1'b0, '0, 128'h04040404_03030303_02020202_01010101,
                   0, 1'b0, 1'b0, 0, 1, 0, 1'b0, 128'h04040404_03030303_02020202_01010101, 6, 32'h0000_0100);
        tv[5] = mk(32'h0000_01F0, 1'b0, '0, 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000,
                   0, 1'b0, 1'b0, 0, 2, 0, 1'b0, 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000, 6, 32'h0000_01F0);
        tv[6] = mk(32'h0000_0200, 1'b0, '0, 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE,
                   0, 1'b0, 1'b0, 0, 0, 2, 1'b0, '0, 0, 32'h0000_0200);
        tv[7] = mk(32'h0000_0300, 1'b0, '0, 128'h76543210_FEDCBA98_DEADBEEF_C001D00D,
                   0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 128'h76543210_FEDCBA98_DEADBEEF_C001D00D, 6, 32'h0000_0300);
        tv[8] = mk(32'h4000_0010, 1'b1, 128'h13579BDF_2468ACE0_0000FFFF_FFFF0000, '0,
                   0, 1'b0, 1'b0, 0, 0, 0, 1'b0, '0, 7, 32'h4000_0010);
        tv[9] = mk(32'h4000_0020, 1'b0, '0, 128'h99999999_88888888_77777777_66666666,
                   0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 128'h99999999_88888888_77777777_66666666, 6, 32'h4000_0020);

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write_en = 1'b0; req_data = '0;
        resp_ready = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        bvalid = 1'b0; bid = '0; bresp = '0;
        repeat (3) @(negedge clk);
        check("reset strobes", 128'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 128'(0));
        check("reset resp_data/araddr", {resp_data[95:0], araddr}, 128'(0));
        check("reset req_ready", 128'(req_ready), 128'(1));
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (!tv[i].chain) repeat (2) @(negedge clk);
            run_txn(i);
            if (tv[i].abort_after > 0) begin
                @(negedge clk);
                rst_n = 1'b0; rvalid = 1'b0; rlast = 1'b0; resp_ready = 1'b0;
                @(negedge clk);
                check($sformatf("row%0d strobes after mid-burst reset", i),
                      128'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 128'(0));
                check($sformatf("row%0d resp_data/araddr after reset", i), {resp_data[95:0], araddr}, 128'(0));
                rst_n = 1'b1;
                @(negedge clk);
                check($sformatf("row%0d req_ready after release", i), 128'(req_ready), 128'(1));
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
Refill/writeback engine between the data cache and the AXI3 master port. It accepts one 128-bit line request on the DCacheReq handshake. A read becomes a 4-beat INCR AXI read burst, assembled into a line and returned on DCacheResp. A write becomes a 4-beat AXI write burst, followed by a write-response wait and a completion beat on DCacheResp. One transaction is in flight at a time.

Parameters:
AXI_ID, 4'h1, value driven on arid/awid/wid
BEATS, 4, beats per line (fixed; line = BEATS*32 = 128 bits)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  DCacheReq valid
req_ready  out  1  DCacheReq ready
req_addr  in  32  line address (bits [3:0] ignored)
req_write_en  in  1  1 = writeback, 0 = refill
req_data  in  128  writeback line, word0 = [31:0]
resp_valid  out  1  DCacheResp valid
resp_ready  in  1  DCacheResp ready
resp_data  out  128  refill line (0 for write completion)
arvalid/arready  out/in  1  AR handshake
araddr  out  32  {addr[31:4],4'b0}
arid/arlen/arsize/arburst/arlock/arcache/arprot  out  4/4/3/2/2/4/3  AXI_ID, 3, 2, 2'b01, 0, 0, 0
rvalid/rready  in/out  1  R handshake
rid/rdata/rresp/rlast  in  4/32/2/1  R payload
awvalid/awready, awaddr, awid/awlen/awsize/awburst/awlock/awcache/awprot  same widths and constants as AR
wvalid/wready  out/in  1  W handshake
wid/wdata/wstrb/wlast  out  4/32/4/1  AXI_ID, beat word, 4'b1111, last beat
bvalid/bready  in/out  1  B handshake
bid/bresp  in  4/2  B payload

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, RESP.
- Reset (rst_n=0 at posedge): state=IDLE; beat counter=0; line buffer=0; all valid/ready outputs 0; addresses 0. Reset mid-transaction abandons it; no AXI cleanup.
- IDLE:
  - req_ready=1, combinational on state only.
  - On req_valid&&req_ready: latch addr (low 4 bits zeroed), write_en and data.
  - Next state is WR_ADDR if write_en, else RD_ADDR.
  - A request is visible on AXI the cycle after acceptance.
- RD_ADDR:
  - arvalid=1 with latched araddr.
  - On arready: go to RD_DATA, counter=0.
  - arvalid stays high and stable until the handshake.
- RD_DATA:
  - rready=1.
  - Each rvalid&&rready stores rdata into line[32*cnt +: 32], then cnt++.
  - On the 4th accepted beat (cnt==3), go to RESP.
  - rlast, rid and rresp are ignored; completion is by beat count only.
- WR_ADDR:
  - awvalid=1.
  - On awready: go to WR_DATA, cnt=0.
  - W is not issued before AW completes.
- WR_DATA:
  - wvalid=1, wdata=line[32*cnt +: 32], wlast=(cnt==3).
  - On wready: cnt++.
  - After beat 3 handshake, go to WR_RESP.
  - wdata is stable while wvalid&&!wready.
- WR_RESP:
  - bready=1.
  - On bvalid: set line buffer=0, go to RESP.
  - bresp and bid are ignored.
- RESP:
  - resp_valid=1, resp_data=line buffer, held stable.
  - On resp_ready: go to IDLE. The next request can be accepted the following cycle (no back-to-back in the same cycle).
- Minimum latency, all slaves ready with zero wait:
  - Read: accept at cycle 0, AR at 1, R beats at 2-5, resp_valid at 6.
  - Write: AW at 1, W at 2-5, B at 6, resp_valid at 7.
- Backpressure on any channel stretches only that state; no timeouts.
- Outputs are registered except req_ready, which is decoded from state.

Test Plan:
- Read refill: req addr 0x1000_0014, write_en=0; slave returns rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444 → araddr=0x1000_0010, arlen=3, arsize=2, arburst=1; resp_data=0x44444444_33333333_22222222_11111111; resp_valid at cycle 6.
- Writeback: req addr 0x0000_2000, data 0xDDDD..._CCCC..._BBBB..._AAAA... → awaddr 0x2000; wdata AAAA.., BBBB.., CCCC.., DDDD.. in order; wstrb=F; wlast only on beat 4; resp_valid only after bvalid; resp_data=0.
- Backpressure: arready delayed 3 cycles, rvalid gaps between beats, wready toggling 1/0, resp_ready low 5 cycles → payloads stable while stalled, no beat lost or duplicated, req_ready=0 throughout.
- Early/absent rlast: slave asserts rlast on beat 2 → bridge still takes 4 beats; rlast never asserted → bridge completes after beat 4.
- Reset mid-burst: rst_n=0 after 2nd R beat → next cycle state IDLE, rready=0, resp_valid=0, req_ready=1 after release; a fresh read then completes correctly.
- Back-to-back: write then read queued with req_valid held high → second request accepted exactly one cycle after the first resp handshake.
